io_controller: RTL and testbench
================================

Name: io_controller

Overview:
- Sequences IN/OUT instructions between the CPU pipeline and an external I/O port using valid/ready handshakes.
- Stalls the pipeline while a transfer is outstanding.
- For IN, produces the register-file write strobe and write data.
- Aborts on a handshake timeout and flags it with a sticky status bit.

Parameters:
DATA_W, 32, data path width
OP_IN, 6'b111110, control_signal encoding for IN
OP_OUT, 6'b111101, control_signal encoding for OUT
TIMEOUT_CYCLES, 256, max cycles in a wait state before abort; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset: one clock; reset is asynchronous and active-low
control_signal  input  6  decoded opcode from the pipeline
instr_valid  input  1  control_signal is valid this cycle
rf_rd_data  input  DATA_W  register value to send on OUT
ext_in_data  input  DATA_W  external input data
ext_in_valid  input  1  external input data available
ext_in_ready  output  1  controller ready to take input
ext_out_data  output  DATA_W  registered output data
ext_out_valid  output  1  output data valid
ext_out_ready  input  1  peripheral accepts output
io_we  output  1  register-file write strobe (IN)
io_rd_data  output  DATA_W  register-file write data (IN)
cpu_stall  output  1  hold pipeline
busy  output  1  state != IDLE
io_timeout  output  1  sticky: last transfer aborted

Behaviour:
- States: IDLE, IN_WAIT, IN_WB, OUT_WAIT. All state, counters and output registers clear asynchronously on rst_n=0.
- Reset values: ext_in_ready=0, ext_out_valid=0, ext_out_data=0, io_we=0, io_rd_data=0, cpu_stall=0, busy=0, io_timeout=0. Reset mid-transfer drops the transfer with no io_we pulse.
- IDLE + instr_valid + OP_IN:
  - Clear io_timeout and the counter.
  - Next state IN_WAIT.
- IDLE + instr_valid + OP_OUT:
  - Capture rf_rd_data into ext_out_data.
  - Clear io_timeout and the counter.
  - Next state OUT_WAIT.
- Any other opcode, or instr_valid=0: stay in IDLE; no stall, no output change.
- IN_WAIT:
  - ext_in_ready=1 (registered, driven from state).
  - On ext_in_valid=1: capture ext_in_data into io_rd_data, next state IN_WB.
- IN_WB:
  - io_we=1 for exactly one cycle, then IDLE.
  - io_rd_data holds its value until the next IN capture.
- OUT_WAIT:
  - ext_out_valid=1; ext_out_data is stable.
  - On ext_out_ready=1: transfer completes, next state IDLE. ext_out_valid drops the following cycle.
- cpu_stall (combinational):
  - High in the accept cycle (IDLE & instr_valid & OP_IN/OP_OUT).
  - High in IN_WAIT and OUT_WAIT.
  - Low in IN_WB, so the instruction retires with the write.
- Timeout:
  - The counter increments each cycle in IN_WAIT/OUT_WAIT.
  - If no handshake completes within TIMEOUT_CYCLES wait cycles: go to IDLE, set io_timeout=1, no io_we pulse, io_rd_data unchanged.
  - A handshake in the same cycle as expiry wins; no timeout is flagged.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Latency:
  - IN with ext_in_valid already high: accept T0, IN_WAIT T1, io_we at T2.
  - OUT with ext_out_ready high: accept T0, transfer at T1, IDLE at T2.
- instr_valid while not in IDLE is ignored; the pipeline is stalled, so none is expected.

Test Plan:
- Reset: rst_n=0 at an arbitrary phase -> all outputs 0 immediately, without waiting for a clock edge; after release, state IDLE.
- IN, peripheral ready: OP_IN, ext_in_valid=1, ext_in_data=32'hAABBCCDD -> cpu_stall high T0–T1, ext_in_ready at T1, io_we=1 only at T2, io_rd_data=AABBCCDD.
- OUT with backpressure: OP_OUT, rf_rd_data=32'h12345678, ext_out_ready low 3 cycles then high -> ext_out_valid high 4 cycles, data stable at 12345678, cpu_stall deasserts after the transfer cycle.
- Invalid opcode: control_signal=6'b000011, instr_valid=1 -> no stall, io_we=0, ext_*_valid/ready stay 0.
- Timeout: TIMEOUT_CYCLES=4, OP_IN with ext_in_valid=0 -> returns to IDLE after 4 wait cycles, io_timeout=1, no io_we. A following valid OUT clears io_timeout.
- Reset mid-transfer: assert rst_n=0 during OUT_WAIT -> ext_out_valid=0 immediately; after release, IDLE with no spurious transfer.

Source files
------------

// File: rtl/io_controller.sv
// IN/OUT instruction sequencer between the CPU pipeline and an external valid/ready I/O port.
// Stalls the pipeline while a transfer is pending and aborts on a handshake timeout.
module io_controller #(
   parameter int unsigned DATA_W         = 32,
   parameter logic [5:0]  OP_IN          = 6'b111110,
   parameter logic [5:0]  OP_OUT         = 6'b111101,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        control_signal,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] rf_rd_data,
   input  logic [DATA_W-1:0] ext_in_data,
   input  logic              ext_in_valid,
   output logic              ext_in_ready,
   output logic [DATA_W-1:0] ext_out_data,
   output logic              ext_out_valid,
   input  logic              ext_out_ready,
   output logic              io_we,
   output logic [DATA_W-1:0] io_rd_data,
   output logic              cpu_stall,
   output logic              busy,
   output logic              io_timeout
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      StIdle,
      StInWait,
      StInWb,
      StOutWait
   } state_e;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_timeout;
   logic              w_timeout_nxt;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] w_out_data_nxt;
   logic [DATA_W-1:0] r_rd_data;
   logic [DATA_W-1:0] w_rd_data_nxt;
   logic              w_acc_in;
   logic              w_acc_out;
   logic              w_expire;

   assign w_acc_in  = instr_valid && (control_signal == OP_IN);
   assign w_acc_out = instr_valid && (control_signal == OP_OUT);
   // Last allowed wait cycle; a zero timeout never expires.
   assign w_expire  = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_cnt      <= '0;
         r_timeout  <= 1'b0;
         r_out_data <= '0;
         r_rd_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_timeout  <= w_timeout_nxt;
         r_out_data <= w_out_data_nxt;
         r_rd_data  <= w_rd_data_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_timeout_nxt  = r_timeout;
      w_out_data_nxt = r_out_data;
      w_rd_data_nxt  = r_rd_data;
      unique case (r_state)
         StIdle: begin
            if (w_acc_in) begin
               w_state_nxt   = StInWait;
               w_cnt_nxt     = '0;
               w_timeout_nxt = 1'b0;
            end else if (w_acc_out) begin
               w_state_nxt    = StOutWait;
               w_cnt_nxt      = '0;
               w_timeout_nxt  = 1'b0;
               w_out_data_nxt = rf_rd_data;
            end
         end
         StInWait: begin
            if (ext_in_valid) begin
               w_state_nxt   = StInWb;
               w_rd_data_nxt = ext_in_data;
            end else if (w_expire) begin
               w_state_nxt   = StIdle;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         StInWb: begin
            w_state_nxt = StIdle;
         end
         StOutWait: begin
            // A handshake on the expiry cycle still completes normally.
            if (ext_out_ready) begin
               w_state_nxt = StIdle;
            end else if (w_expire) begin
               w_state_nxt   = StIdle;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   assign ext_in_ready  = (r_state == StInWait);
   assign ext_out_valid = (r_state == StOutWait);
   assign ext_out_data  = r_out_data;
   assign io_we         = (r_state == StInWb);
   assign io_rd_data    = r_rd_data;
   assign busy          = (r_state != StIdle);
   assign io_timeout    = r_timeout;
   assign cpu_stall     = ((r_state == StIdle) && (w_acc_in || w_acc_out)) ||
                          (r_state == StInWait) || (r_state == StOutWait);

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: IN, OUT with backpressure, bad opcode, timeout,
// and asynchronous reset mid-transfer.
module tb_io_controller;

   localparam logic [5:0] OpIn  = 6'b111110;
   localparam logic [5:0] OpOut = 6'b111101;

   logic        clk;
   logic        rst_n;
   logic [5:0]  control_signal;
   logic        instr_valid;
   logic [31:0] rf_rd_data;
   logic [31:0] ext_in_data;
   logic        ext_in_valid;
   logic        ext_in_ready;
   logic [31:0] ext_out_data;
   logic        ext_out_valid;
   logic        ext_out_ready;
   logic        io_we;
   logic [31:0] io_rd_data;
   logic        cpu_stall;
   logic        busy;
   logic        io_timeout;

   int n_total = 0;
   int n_bad   = 0;

   io_controller #(
      .DATA_W        (32),
      .OP_IN         (OpIn),
      .OP_OUT        (OpOut),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .control_signal(control_signal),
      .instr_valid   (instr_valid),
      .rf_rd_data    (rf_rd_data),
      .ext_in_data   (ext_in_data),
      .ext_in_valid  (ext_in_valid),
      .ext_in_ready  (ext_in_ready),
      .ext_out_data  (ext_out_data),
      .ext_out_valid (ext_out_valid),
      .ext_out_ready (ext_out_ready),
      .io_we         (io_we),
      .io_rd_data    (io_rd_data),
      .cpu_stall     (cpu_stall),
      .busy          (busy),
      .io_timeout    (io_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b1;
      control_signal = 6'b0;
      instr_valid    = 1'b0;
      rf_rd_data     = 32'h0;
      ext_in_data    = 32'h0;
      ext_in_valid   = 1'b0;
      ext_out_ready  = 1'b0;

      // Reset asserted between edges: outputs must clear without a clock.
      #3 rst_n = 1'b0;
      #1;
      check_eq("rst_stall", cpu_stall, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_in_ready", ext_in_ready, 0);
      check_eq("rst_out_valid", ext_out_valid, 0);
      check_eq("rst_out_data", ext_out_data, 0);
      check_eq("rst_we", io_we, 0);
      check_eq("rst_rd_data", io_rd_data, 0);
      check_eq("rst_timeout", io_timeout, 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_busy", busy, 0);

      // IN with peripheral data already valid.
      cyc();
      instr_valid    = 1'b1;
      control_signal = OpIn;
      ext_in_valid   = 1'b1;
      ext_in_data    = 32'hAABBCCDD;
      #1;
      check_eq("in_t0_stall", cpu_stall, 1);
      check_eq("in_t0_ready", ext_in_ready, 0);
      check_eq("in_t0_we", io_we, 0);
      cyc();
      instr_valid = 1'b0;
      #1;
      check_eq("in_t1_stall", cpu_stall, 1);
      check_eq("in_t1_ready", ext_in_ready, 1);
      check_eq("in_t1_we", io_we, 0);
      check_eq("in_t1_busy", busy, 1);
      cyc();
      ext_in_valid = 1'b0;
      ext_in_data  = 32'h0;
      #1;
      check_eq("in_t2_we", io_we, 1);
      check_eq("in_t2_stall", cpu_stall, 0);
      check_eq("in_t2_ready", ext_in_ready, 0);
      check_eq("in_t2_data", io_rd_data, 32'hAABBCCDD);
      cyc();
      #1;
      check_eq("in_t3_we", io_we, 0);
      check_eq("in_t3_busy", busy, 0);
      check_eq("in_t3_data", io_rd_data, 32'hAABBCCDD);

      // OUT with three cycles of backpressure; ready arrives on the expiry cycle.
      cyc();
      instr_valid    = 1'b1;
      control_signal = OpOut;
      rf_rd_data     = 32'h12345678;
      ext_out_ready  = 1'b0;
      #1;
      check_eq("out_t0_stall", cpu_stall, 1);
      check_eq("out_t0_valid", ext_out_valid, 0);
      cyc();
      instr_valid = 1'b0;
      rf_rd_data  = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         ext_out_ready = (k == 3);
         #1;
         check_eq($sformatf("out_w%0d_valid", k), ext_out_valid, 1);
         check_eq($sformatf("out_w%0d_data", k), ext_out_data, 32'h12345678);
         check_eq($sformatf("out_w%0d_stall", k), cpu_stall, 1);
         cyc();
      end
      ext_out_ready = 1'b0;
      #1;
      check_eq("out_done_valid", ext_out_valid, 0);
      check_eq("out_done_stall", cpu_stall, 0);
      check_eq("out_done_busy", busy, 0);
      check_eq("out_done_timeout", io_timeout, 0);

      // Unrecognised opcode is ignored.
      cyc();
      instr_valid    = 1'b1;
      control_signal = 6'b000011;
      rf_rd_data     = 32'hCAFEF00D;
      #1;
      check_eq("bad_op_stall", cpu_stall, 0);
      cyc();
      instr_valid = 1'b0;
      #1;
      check_eq("bad_op_busy", busy, 0);
      check_eq("bad_op_in_ready", ext_in_ready, 0);
      check_eq("bad_op_out_valid", ext_out_valid, 0);
      check_eq("bad_op_we", io_we, 0);
      check_eq("bad_op_out_data", ext_out_data, 32'h12345678);

      // IN that never gets data: abort after four wait cycles.
      cyc();
      instr_valid    = 1'b1;
      control_signal = OpIn;
      ext_in_valid   = 1'b0;
      ext_in_data    = 32'h11111111;
      #1;
      check_eq("to_t0_stall", cpu_stall, 1);
      cyc();
      instr_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq($sformatf("to_w%0d_ready", k), ext_in_ready, 1);
         check_eq($sformatf("to_w%0d_flag", k), io_timeout, 0);
         cyc();
      end
      #1;
      check_eq("to_idle_ready", ext_in_ready, 0);
      check_eq("to_idle_busy", busy, 0);
      check_eq("to_idle_stall", cpu_stall, 0);
      check_eq("to_flag", io_timeout, 1);
      check_eq("to_we", io_we, 0);
      check_eq("to_rd_data", io_rd_data, 32'hAABBCCDD);
      cyc();
      #1;
      check_eq("to_we_after", io_we, 0);
      check_eq("to_flag_sticky", io_timeout, 1);

      // Next accepted OUT clears the sticky flag.
      cyc();
      instr_valid    = 1'b1;
      control_signal = OpOut;
      rf_rd_data     = 32'h0F0F0F0F;
      ext_out_ready  = 1'b1;
      #1;
      check_eq("clr_t0_flag", io_timeout, 1);
      cyc();
      instr_valid = 1'b0;
      #1;
      check_eq("clr_t1_flag", io_timeout, 0);
      check_eq("clr_t1_valid", ext_out_valid, 1);
      check_eq("clr_t1_data", ext_out_data, 32'h0F0F0F0F);
      cyc();
      ext_out_ready = 1'b0;
      #1;
      check_eq("clr_t2_valid", ext_out_valid, 0);

      // Reset during OUT_WAIT drops the transfer immediately.
      cyc();
      instr_valid    = 1'b1;
      control_signal = OpOut;
      rf_rd_data     = 32'h55AA55AA;
      cyc();
      instr_valid = 1'b0;
      #1;
      check_eq("mid_valid_before", ext_out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", ext_out_valid, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_stall", cpu_stall, 0);
      check_eq("mid_rst_data", ext_out_data, 0);
      cyc();
      cyc();
      rst_n         = 1'b1;
      ext_out_ready = 1'b1;
      cyc();
      #1;
      check_eq("mid_post_busy", busy, 0);
      check_eq("mid_post_valid", ext_out_valid, 0);
      check_eq("mid_post_we", io_we, 0);
      check_eq("mid_post_data", ext_out_data, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
